// File: rtl/data_memory_bhw.sv
// Byte-addressable big-endian data memory for the MEM stage.
// Byte/half/word loads and stores; bad requests are dropped and flagged.
module data_memory_bhw #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [ADDR_W-1:0] IE_MEM_ALUresult,
  input  logic [DATA_W-1:0] IE_MEM_rt,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  output logic [DATA_W-1:0] MEM_WB_ReadData,
  output logic              MEM_WB_ReadValid,
  output logic              MemErr,
  output logic [1:0]        MemErrCode
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [7:0] mem [DEPTH];

  logic [2:0]        nbytes;
  logic [ADDR_W:0]   last_addr;
  logic              misal;
  logic              oor;
  logic              req;
  logic [1:0]        code;
  logic              acc_rd;
  logic              acc_wr;
  logic [IW-1:0]     idx   [4];
  logic [7:0]        rlane [4];
  logic [7:0]        wlane [4];
  logic [3:0]        wen;
  logic              sx;
  logic [DATA_W-1:0] ld_val;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  always_comb begin
    unique case (MemSize)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    misal = (MemSize == 2'b01 && IE_MEM_ALUresult[0]) ||
            (MemSize == 2'b10 && IE_MEM_ALUresult[1:0] != 2'b00);
    // one extra bit so an address near the top cannot wrap to zero
    last_addr = {1'b0, IE_MEM_ALUresult}
              + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    oor = last_addr >= DEPTH_X;
    req = MemRead | MemWrite;
    if (MemSize == 2'b11)       code = 2'b11;
    else if (MemRead && MemWrite) code = 2'b11;
    else if (misal)             code = 2'b01;
    else if (oor)               code = 2'b10;
    else                        code = 2'b00;
    acc_rd = MemRead  && code == 2'b00;
    acc_wr = MemWrite && code == 2'b00;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k]   = IE_MEM_ALUresult[IW-1:0] + IW'(k);
      rlane[k] = mem[idx[k]];
      wlane[k] = 8'h00;
    end
    wen = 4'b0000;
    sx  = ~MemUnsigned & rlane[0][7];
    unique case (MemSize)
      2'b00: begin
        ld_val   = {{24{sx}}, rlane[0]};
        wlane[0] = IE_MEM_rt[7:0];
        wen      = {3'b000, acc_wr};
      end
      2'b01: begin
        ld_val   = {{16{sx}}, rlane[0], rlane[1]};
        wlane[0] = IE_MEM_rt[15:8];
        wlane[1] = IE_MEM_rt[7:0];
        wen      = {2'b00, {2{acc_wr}}};
      end
      default: begin
        ld_val   = {rlane[0], rlane[1], rlane[2], rlane[3]};
        wlane[0] = IE_MEM_rt[31:24];
        wlane[1] = IE_MEM_rt[23:16];
        wlane[2] = IE_MEM_rt[15:8];
        wlane[3] = IE_MEM_rt[7:0];
        wen      = {4{acc_wr}};
      end
    endcase
  end

  always_comb begin
    rdata_d  = acc_rd ? ld_val : rdata_q;
    rvalid_d = acc_rd;
    err_d    = req && code != 2'b00;
    code_d   = req ? code : 2'b00;
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      if (wen[k]) mem[idx[k]] <= wlane[k];
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign MEM_WB_ReadData  = rdata_q;
  assign MEM_WB_ReadValid = rvalid_q;
  assign MemErr           = err_q;
  assign MemErrCode       = code_q;

endmodule

// File: tb/tb_data_memory_bhw.sv
// Bench for data_memory_bhw: byte-array model plus directed
// vectors with literal expectations.
module tb_data_memory_bhw;

  localparam int DEPTH = 128;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [31:0] addr_i;
  logic [31:0] rt_i;
  logic        rd_i, wr_i, uns_i;
  logic [1:0]  sz_i;
  logic [31:0] rdata;
  logic        rvalid, err;
  logic [1:0]  ecode;

  data_memory_bhw #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK              (CLK),
    .RST_n            (RST_n),
    .IE_MEM_ALUresult (addr_i),
    .IE_MEM_rt        (rt_i),
    .MemRead          (rd_i),
    .MemWrite         (wr_i),
    .MemSize          (sz_i),
    .MemUnsigned      (uns_i),
    .MEM_WB_ReadData  (rdata),
    .MEM_WB_ReadValid (rvalid),
    .MemErr           (err),
    .MemErrCode       (ecode)
  );

  always #5 CLK = ~CLK;

  logic [7:0]  model [DEPTH];
  logic [31:0] e_data;
  logic        e_valid, e_err;
  logic [1:0]  e_code;
  bit          cmp_en;
  int          checks;
  int          errors;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] d,
                     input logic v, input logic e, input logic [1:0] c);
    chk({nm, ".data"},  rdata, d);
    chk({nm, ".valid"}, {31'b0, rvalid}, {31'b0, v});
    chk({nm, ".err"},   {31'b0, err},    {31'b0, e});
    chk({nm, ".code"},  {30'b0, ecode},  {30'b0, c});
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("model.data",  rdata, e_data);
      chk("model.valid", {31'b0, rvalid}, {31'b0, e_valid});
      chk("model.err",   {31'b0, err},    {31'b0, e_err});
      chk("model.code",  {30'b0, ecode},  {30'b0, e_code});
    end
  end

  // one request per clock; the model decides outcome from plain arithmetic
  task automatic op(input bit rd, input bit wr, input bit [1:0] sz,
                    input bit uns, input bit [31:0] a, input bit [31:0] wd);
    int          nb;
    bit [1:0]    c;
    logic [31:0] v;
    rd_i = rd; wr_i = wr; sz_i = sz; uns_i = uns;
    addr_i = a; rt_i = wd;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    c = 2'd0;
    if (rd || wr) begin
      if (sz == 2'd3)                               c = 2'd3;
      else if (rd && wr)                            c = 2'd3;
      else if (a % nb != 0)                         c = 2'd1;
      else if (64'(a) + 64'(nb) > 64'(DEPTH))       c = 2'd2;
    end
    @(posedge CLK);
    e_valid = 1'b0;
    e_err   = (c != 2'd0);
    e_code  = c;
    if (c == 2'd0 && rd) begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v = (v << 8) | 32'(model[a + k]);
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 1);
      e_data  = v;
      e_valid = 1'b1;
    end
    if (c == 2'd0 && wr) begin
      for (int k = 0; k < nb; k++) model[a + k] = 8'(wd >> (8*(nb-1-k)));
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    checks = 0; errors = 0; cmp_en = 1'b0;
    RST_n = 1'b0;
    rd_i = 0; wr_i = 0; sz_i = 0; uns_i = 0; addr_i = 0; rt_i = 0;
    e_data = 0; e_valid = 0; e_err = 0; e_code = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    lit("reset", 32'h0, 1'b0, 1'b0, 2'd0);
    RST_n = 1'b1;
    cmp_en = 1'b1;

    for (int i = 0; i < DEPTH / 4; i++)
      op(0, 1, 2'd2, 0, 32'(i * 4), 32'(i) * 32'h0101_0101 + 32'h1020_3040);

    op(0, 1, 2'd2, 0, 32'd0, 32'h8081_7F01);
    op(1, 0, 2'd2, 0, 32'd0, 32'h0);
    lit("lw0", 32'h8081_7F01, 1'b1, 1'b0, 2'd0);
    idle();
    lit("pulse", 32'h8081_7F01, 1'b0, 1'b0, 2'd0);

    op(1, 0, 2'd0, 0, 32'd1, 32'h0);
    lit("lb1", 32'hFFFF_FF81, 1'b1, 1'b0, 2'd0);
    op(1, 0, 2'd0, 1, 32'd1, 32'h0);
    lit("lbu1", 32'h0000_0081, 1'b1, 1'b0, 2'd0);
    op(1, 0, 2'd1, 0, 32'd2, 32'h0);
    lit("lh2", 32'h0000_7F01, 1'b1, 1'b0, 2'd0);
    op(1, 0, 2'd1, 0, 32'd0, 32'h0);
    lit("lh0", 32'hFFFF_8081, 1'b1, 1'b0, 2'd0);
    op(1, 0, 2'd1, 1, 32'd0, 32'h0);
    lit("lhu0", 32'h0000_8081, 1'b1, 1'b0, 2'd0);

    op(0, 1, 2'd0, 0, 32'd2, 32'h0000_00AA);
    op(1, 0, 2'd2, 0, 32'd0, 32'h0);
    lit("sb2", 32'h8081_AA01, 1'b1, 1'b0, 2'd0);
    op(0, 1, 2'd1, 0, 32'd0, 32'h0000_1234);
    op(1, 0, 2'd2, 0, 32'd0, 32'h0);
    lit("sh0", 32'h1234_AA01, 1'b1, 1'b0, 2'd0);

    op(1, 0, 2'd2, 0, 32'd2, 32'h0);
    lit("lw2mis", 32'h1234_AA01, 1'b0, 1'b1, 2'd1);
    op(0, 1, 2'd1, 0, 32'd3, 32'h0000_5555);
    lit("sh3mis", 32'h1234_AA01, 1'b0, 1'b1, 2'd1);
    op(1, 0, 2'd2, 0, 32'd0, 32'h0);
    lit("aftmis", 32'h1234_AA01, 1'b1, 1'b0, 2'd0);

    op(0, 1, 2'd2, 0, 32'd124, 32'hCAFE_F00D);
    op(1, 0, 2'd2, 0, 32'd124, 32'h0);
    lit("lw124", 32'hCAFE_F00D, 1'b1, 1'b0, 2'd0);
    op(1, 0, 2'd2, 0, 32'd128, 32'h0);
    lit("lw128", 32'hCAFE_F00D, 1'b0, 1'b1, 2'd2);
    op(0, 1, 2'd0, 0, 32'd127, 32'h0000_005A);
    lit("sb127", 32'hCAFE_F00D, 1'b0, 1'b0, 2'd0);
    op(1, 0, 2'd0, 1, 32'd127, 32'h0);
    lit("lbu127", 32'h0000_005A, 1'b1, 1'b0, 2'd0);
    op(0, 1, 2'd1, 0, 32'd127, 32'h0000_7777);
    lit("sh127", 32'h0000_005A, 1'b0, 1'b1, 2'd1);
    op(1, 0, 2'd0, 0, 32'd128, 32'h0);
    lit("lb128", 32'h0000_005A, 1'b0, 1'b1, 2'd2);
    op(1, 0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0);
    lit("lwtop", 32'h0000_005A, 1'b0, 1'b1, 2'd2);
    op(1, 0, 2'd3, 0, 32'd0, 32'h0);
    lit("rsvd", 32'h0000_005A, 1'b0, 1'b1, 2'd3);

    op(1, 1, 2'd2, 0, 32'd0, 32'hDEAD_BEEF);
    lit("rdwr", 32'h0000_005A, 1'b0, 1'b1, 2'd3);
    op(1, 0, 2'd2, 0, 32'd0, 32'h0);
    lit("afterrw", 32'h1234_AA01, 1'b1, 1'b0, 2'd0);

    op(1, 0, 2'd2, 0, 32'd124, 32'h0);
    rd_i = 0; wr_i = 0;
    #2;
    RST_n = 1'b0;
    e_data = 0; e_valid = 0; e_err = 0; e_code = 0;
    #1;
    lit("asyncrst", 32'h0, 1'b0, 1'b0, 2'd0);
    @(posedge CLK);
    @(negedge CLK);
    #1 RST_n = 1'b1;
    op(1, 0, 2'd2, 0, 32'd0, 32'h0);
    lit("postrst", 32'h1234_AA01, 1'b1, 1'b0, 2'd0);
    op(1, 0, 2'd2, 0, 32'd124, 32'h0);
    lit("postrst124", 32'hCAFE_F05A, 1'b1, 1'b0, 2'd0);
    idle();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
